// File: rtl/control_unit_pipe_pkg.sv
// Shared encodings for the decode-stage control unit: opcodes, control-bundle
// field encodings, FSM state codes and the reset/safe bundle.
package control_unit_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} imm_sel_e;
  typedef enum logic {DATA1, PC} alu_sel1_e;
  typedef enum logic {DATA2, IMM} alu_sel2_e;
  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_op_e;
  typedef enum logic [2:0] {B_NO, B_EQ, B_NE, B_LT, B_GE, B_LTU, B_GEU, B_JUMP} branch_e;
  typedef enum logic [1:0] {NO_W, MW_SB, MW_SH, MW_SW} mem_write_e;
  typedef enum logic [2:0] {NO_R, MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU} mem_read_e;
  typedef enum logic [1:0] {ALU, MEM, PC_4, IMM_WB} wb_sel_e;
  typedef enum logic {DIS, EN} write_en_e;
  typedef enum logic {IDLE, MD_BUSY} state_e;

  typedef struct packed {
    imm_sel_e   imm_sel;
    alu_sel1_e  alu_sel1;
    alu_sel2_e  alu_sel2;
    alu_op_e    alu_op;
    branch_e    branch;
    mem_write_e mem_write;
    mem_read_e  mem_read;
    wb_sel_e    wb_sel;
    write_en_e  write_en;
    logic [4:0] rd;
    logic       is_m;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{
    imm_sel: I_TYPE, alu_sel1: DATA1, alu_sel2: DATA2, alu_op: ADD,
    branch: B_NO, mem_write: NO_W, mem_read: NO_R, wb_sel: ALU,
    write_en: DIS, rd: 5'd0, is_m: 1'b0
  };

endpackage

// File: rtl/control_unit_pipe_decoder.sv
// Purely combinational RV32I/M instruction decoder producing the control bundle.
module control_decoder
  import control_unit_pipe_pkg::*;
#(
  parameter int EN_M_EXT = 1
) (
  input  logic [31:0] instruction,
  output bundle_t     bundle,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;
  bundle_t    b;
  logic       ill;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7        = instruction[31:25];
  assign unused_fields = ^instruction[24:15];

  always_comb begin
    b        = BUNDLE_RST;
    b.rd     = instruction[11:7];
    ill      = 1'b0;
    case (opcode)
      OP_R: begin
        b.write_en = EN;
        case (funct7)
          F7_BASE: case (funct3)
            3'b000: b.alu_op = ADD;
            3'b001: b.alu_op = SLL;
            3'b010: b.alu_op = SLT;
            3'b011: b.alu_op = SLTU;
            3'b100: b.alu_op = XOR;
            3'b101: b.alu_op = SRL;
            3'b110: b.alu_op = OR;
            default: b.alu_op = AND;
          endcase
          F7_ALT: case (funct3)
            3'b000: b.alu_op = SUB;
            3'b101: b.alu_op = SRA;
            default: ill = 1'b1;
          endcase
          F7_MUL: begin
            if (EN_M_EXT != 0) begin
              b.is_m = 1'b1;
              case (funct3)
                3'b000: b.alu_op = MUL;
                3'b001: b.alu_op = MULH;
                3'b010: b.alu_op = MULHSU;
                3'b011: b.alu_op = MULHU;
                3'b100: b.alu_op = DIV;
                3'b101: b.alu_op = DIVU;
                3'b110: b.alu_op = REM;
                default: b.alu_op = REMU;
              endcase
            end else begin
              ill = 1'b1;
            end
          end
          default: ill = 1'b1;
        endcase
      end
      OP_I: begin
        b.write_en = EN;
        b.alu_sel2 = IMM;
        case (funct3)
          3'b000: b.alu_op = ADD;
          3'b010: b.alu_op = SLT;
          3'b011: b.alu_op = SLTU;
          3'b100: b.alu_op = XOR;
          3'b110: b.alu_op = OR;
          3'b111: b.alu_op = AND;
          3'b001: if (funct7 == F7_BASE) b.alu_op = SLL; else ill = 1'b1;
          default: begin
            if (funct7 == F7_BASE)     b.alu_op = SRL;
            else if (funct7 == F7_ALT) b.alu_op = SRA;
            else                       ill = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        b.write_en = EN;
        b.alu_sel2 = IMM;
        b.wb_sel   = MEM;
        case (funct3)
          3'b000: b.mem_read = MR_LB;
          3'b001: b.mem_read = MR_LH;
          3'b010: b.mem_read = MR_LW;
          3'b100: b.mem_read = MR_LBU;
          3'b101: b.mem_read = MR_LHU;
          default: ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        b.imm_sel  = S_TYPE;
        b.alu_sel2 = IMM;
        case (funct3)
          3'b000: b.mem_write = MW_SB;
          3'b001: b.mem_write = MW_SH;
          3'b010: b.mem_write = MW_SW;
          default: ill = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        b.imm_sel = B_TYPE;
        case (funct3)
          3'b000: b.branch = B_EQ;
          3'b001: b.branch = B_NE;
          3'b100: b.branch = B_LT;
          3'b101: b.branch = B_GE;
          3'b110: b.branch = B_LTU;
          3'b111: b.branch = B_GEU;
          default: ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        b.imm_sel  = J_TYPE;
        b.alu_sel1 = PC;
        b.alu_sel2 = IMM;
        b.branch   = B_JUMP;
        b.wb_sel   = PC_4;
        b.write_en = EN;
      end
      OP_JALR: begin
        b.alu_sel2 = IMM;
        b.branch   = B_JUMP;
        b.wb_sel   = PC_4;
        b.write_en = EN;
        if (funct3 != 3'b000) ill = 1'b1;
      end
      OP_AUIPC: begin
        b.imm_sel  = U_TYPE;
        b.alu_sel1 = PC;
        b.alu_sel2 = IMM;
        b.write_en = EN;
      end
      OP_LUI: begin
        b.imm_sel  = U_TYPE;
        b.alu_sel2 = IMM;
        b.wb_sel   = IMM_WB;
        b.write_en = EN;
      end
      default: ill = 1'b1;
    endcase
    // Illegal ops collapse to the safe bundle; RD is meaningless without a write.
    if (ill) b = BUNDLE_RST;
    if (b.write_en == DIS) b.rd = '0;
  end

  assign bundle  = b;
  assign illegal = ill;

endmodule

// File: rtl/control_unit_pipe.sv
// Decode-stage control unit: registered control bundle with a multi-cycle
// hold of the stage for RV32M ops.
module control_unit_pipe
  import control_unit_pipe_pkg::*;
#(
  parameter int EN_M_EXT   = 1,
  parameter int MD_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IN_VALID,
  input  logic        STALL_IN,
  input  logic        FLUSH,
  output logic [2:0]  IMM_SEL,
  output logic        ALU_SEL1,
  output logic        ALU_SEL2,
  output logic [4:0]  ALU_OP,
  output logic [2:0]  BRANCH,
  output logic [1:0]  MEM_WRITE,
  output logic [2:0]  MEM_READ,
  output logic [1:0]  WB_SEL,
  output logic        WRITE_EN,
  output logic [4:0]  RD,
  output logic        OUT_VALID,
  output logic        ILLEGAL,
  output logic        STALL_OUT
);

  bundle_t          dec_bundle, bun_q, bun_d;
  logic             dec_illegal;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ill_q, ill_d;
  logic             unused_is_m;

  control_decoder #(.EN_M_EXT(EN_M_EXT)) u_decoder (
    .instruction (INSTRUCTION),
    .bundle      (dec_bundle),
    .illegal     (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    bun_d   = bun_q;
    if (FLUSH) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (STALL_IN) begin
      // hold everything
    end else if (state_q == MD_BUSY) begin
      if (cnt_q == '0) begin
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (IN_VALID) begin
      bun_d = dec_bundle;
      ill_d = dec_illegal;
      if (dec_bundle.is_m && MD_LATENCY > 1) begin
        state_d = MD_BUSY;
        cnt_d   = CNT_W'(MD_LATENCY - 2);
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      bun_q   <= BUNDLE_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      bun_q   <= bun_d;
    end
  end

  assign STALL_OUT   = (state_q == MD_BUSY) || STALL_IN;
  assign OUT_VALID   = valid_q;
  assign ILLEGAL     = ill_q;
  assign IMM_SEL     = bun_q.imm_sel;
  assign ALU_SEL1    = bun_q.alu_sel1;
  assign ALU_SEL2    = bun_q.alu_sel2;
  assign ALU_OP      = bun_q.alu_op;
  assign BRANCH      = bun_q.branch;
  assign MEM_WRITE   = bun_q.mem_write;
  assign MEM_READ    = bun_q.mem_read;
  assign WB_SEL      = bun_q.wb_sel;
  assign WRITE_EN    = bun_q.write_en;
  assign RD          = bun_q.rd;
  assign unused_is_m = bun_q.is_m;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: a default instance plus one with the
// M extension disabled, driven from the same stimulus.
module tb_control_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid, stall_in, flush;

  logic [2:0] imm_sel, branch, mem_read;
  logic       alu_sel1, alu_sel2, write_en, out_valid, illegal, stall_out;
  logic [4:0] alu_op, rd;
  logic [1:0] mem_write, wb_sel;

  logic [2:0] n_imm_sel, n_branch, n_mem_read;
  logic       n_alu_sel1, n_alu_sel2, n_write_en, n_out_valid, n_illegal, n_stall_out;
  logic [4:0] n_alu_op, n_rd;
  logic [1:0] n_mem_write, n_wb_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit_pipe #(.EN_M_EXT(1), .MD_LATENCY(4)) dut (
    .CLK(clk), .RESET(rst_n), .INSTRUCTION(instr), .IN_VALID(in_valid),
    .STALL_IN(stall_in), .FLUSH(flush), .IMM_SEL(imm_sel), .ALU_SEL1(alu_sel1),
    .ALU_SEL2(alu_sel2), .ALU_OP(alu_op), .BRANCH(branch), .MEM_WRITE(mem_write),
    .MEM_READ(mem_read), .WB_SEL(wb_sel), .WRITE_EN(write_en), .RD(rd),
    .OUT_VALID(out_valid), .ILLEGAL(illegal), .STALL_OUT(stall_out)
  );

  control_unit_pipe #(.EN_M_EXT(0), .MD_LATENCY(4)) dut_nm (
    .CLK(clk), .RESET(rst_n), .INSTRUCTION(instr), .IN_VALID(in_valid),
    .STALL_IN(stall_in), .FLUSH(flush), .IMM_SEL(n_imm_sel), .ALU_SEL1(n_alu_sel1),
    .ALU_SEL2(n_alu_sel2), .ALU_OP(n_alu_op), .BRANCH(n_branch), .MEM_WRITE(n_mem_write),
    .MEM_READ(n_mem_read), .WB_SEL(n_wb_sel), .WRITE_EN(n_write_en), .RD(n_rd),
    .OUT_VALID(n_out_valid), .ILLEGAL(n_illegal), .STALL_OUT(n_stall_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    #1;
    chk("rst_valid",   32'(out_valid), 0);
    chk("rst_illegal", 32'(illegal),   0);
    chk("rst_alu_op",  32'(alu_op),    0);
    chk("rst_branch",  32'(branch),    0);
    chk("rst_mem",     32'({mem_write, mem_read}), 0);
    chk("rst_we_rd",   32'({write_en, rd}), 0);
    chk("rst_sels",    32'({wb_sel, imm_sel, alu_sel1, alu_sel2}), 0);
    chk("rst_stall",   32'(stall_out), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 0);

    // ADD x3,x1,x2
    instr = 32'h002081B3; in_valid = 1'b1;
    tick();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_op",    32'(alu_op),    0);
    chk("add_we",    32'(write_en),  1);
    chk("add_rd",    32'(rd),        3);
    chk("add_stall", 32'(stall_out), 0);
    chk("add_ill",   32'(illegal),   0);

    // MUL x5,x6,x7: three stall cycles, valid on the fourth
    instr = 32'h027302B3;
    tick();
    in_valid = 1'b0;
    chk("mul_c1_stall", 32'(stall_out), 1);
    chk("mul_c1_valid", 32'(out_valid), 0);
    chk("nm_mul_valid", 32'(n_out_valid), 1);
    chk("nm_mul_ill",   32'(n_illegal),   1);
    chk("nm_mul_we",    32'(n_write_en),  0);
    chk("nm_mul_rd",    32'(n_rd),        0);
    chk("nm_mul_stall", 32'(n_stall_out), 0);
    tick();
    chk("mul_c2_stall", 32'(stall_out), 1);
    chk("mul_c2_valid", 32'(out_valid), 0);
    tick();
    chk("mul_c3_stall", 32'(stall_out), 1);
    chk("mul_c3_valid", 32'(out_valid), 0);
    tick();
    chk("mul_c4_stall", 32'(stall_out), 0);
    chk("mul_c4_valid", 32'(out_valid), 1);
    chk("mul_op",       32'(alu_op),    10);
    chk("mul_rd",       32'(rd),        5);
    tick();
    chk("mul_after_valid", 32'(out_valid), 0);

    // LW x4,8(x2) under a 2-cycle downstream stall
    instr = 32'h00812203; in_valid = 1'b1; stall_in = 1'b1;
    tick();
    chk("lw_s1_valid", 32'(out_valid), 0);
    chk("lw_s1_stall", 32'(stall_out), 1);
    tick();
    chk("lw_s2_valid", 32'(out_valid), 0);
    stall_in = 1'b0;
    tick();
    chk("lw_valid", 32'(out_valid), 1);
    chk("lw_mr",    32'(mem_read),  3);
    chk("lw_wb",    32'(wb_sel),    1);
    chk("lw_rd",    32'(rd),        4);
    chk("lw_sel2",  32'(alu_sel2),  1);
    instr = 32'h002081B3; stall_in = 1'b1;
    tick();
    chk("hold1_valid", 32'(out_valid), 1);
    chk("hold1_mr",    32'(mem_read),  3);
    tick();
    chk("hold2_rd",    32'(rd),        4);
    chk("hold2_valid", 32'(out_valid), 1);
    stall_in = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_hold_valid", 32'(out_valid), 0);

    // MUL flushed while busy: no valid pulse
    instr = 32'h027302B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_stall", 32'(stall_out), 0);
    chk("flush_valid", 32'(out_valid), 0);
    tick();
    chk("flush_nopulse1", 32'(out_valid), 0);
    tick();
    chk("flush_nopulse2", 32'(out_valid), 0);

    // FLUSH coincident with IN_VALID discards the instruction
    instr = 32'h002081B3; in_valid = 1'b1; flush = 1'b1;
    tick();
    chk("flush_inv_valid", 32'(out_valid), 0);
    flush = 1'b0;

    // directed decode vectors
    instr = 32'h40208133; tick();  // SUB x2,x1,x2
    chk("sub_op", 32'(alu_op), 1);
    chk("sub_rd", 32'(rd),     2);
    instr = 32'h40115093; tick();  // SRAI x1,x2,1
    chk("srai_op",  32'(alu_op),   7);
    chk("srai_sel", 32'(alu_sel2), 1);
    chk("srai_ill", 32'(illegal),  0);
    instr = 32'h40109093; tick();  // SLLI with bad funct7
    chk("slli_bad_ill", 32'(illegal),   1);
    chk("slli_bad_v",   32'(out_valid), 1);
    chk("slli_bad_we",  32'(write_en),  0);
    instr = 32'h0020B023; tick();  // store funct3 011
    chk("sd_ill", 32'(illegal),   1);
    chk("sd_mw",  32'(mem_write), 0);
    instr = 32'h0020A063; tick();  // branch funct3 010
    chk("br010_ill", 32'(illegal), 1);
    chk("br010_br",  32'(branch),  0);
    instr = 32'h00209463; tick();  // BNE, rd field nonzero
    chk("bne_br",  32'(branch),  2);
    chk("bne_rd",  32'(rd),      0);
    chk("bne_imm", 32'(imm_sel), 2);
    chk("bne_ill", 32'(illegal), 0);
    instr = 32'h008000EF; tick();  // JAL x1
    chk("jal_wb",   32'(wb_sel),   2);
    chk("jal_rd",   32'(rd),       1);
    chk("jal_sel1", 32'(alu_sel1), 1);
    instr = 32'h123452B7; tick();  // LUI x5
    chk("lui_wb",  32'(wb_sel),  3);
    chk("lui_imm", 32'(imm_sel), 3);
    chk("lui_rd",  32'(rd),      5);
    in_valid = 1'b0;
    tick();

    // Reset during MD_BUSY aborts the op
    instr = 32'h027302B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_stall", 32'(stall_out), 0);
    chk("arst_op",    32'(alu_op),    0);
    chk("arst_rd",    32'(rd),        0);
    chk("arst_ill",   32'(illegal),   0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_nopulse1", 32'(out_valid), 0);
    tick();
    chk("arst_nopulse2", 32'(out_valid), 0);
    chk("arst_stall2",   32'(stall_out), 0);

    instr = 32'hFFFFFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ones_valid", 32'(out_valid), 1);
    chk("ones_ill",   32'(illegal),   1);
    chk("ones_we_rd", 32'({write_en, rd}), 0);
    chk("ones_mem",   32'({mem_write, mem_read}), 0);
    chk("ones_br",    32'(branch),    0);
    tick();
    chk("ones_after", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
